// File: rtl/id_ex_hazard_pkg.sv
// Shared WISC definitions for the issue stage: opcode values, the NOP encoding,
// register-index width and the scoreboard entry layout.
package id_ex_hazard_pkg;

  localparam int REG_W  = 3;
  localparam int INST_W = 16;

  localparam logic [INST_W-1:0] NOP_INST = 16'h0800;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_SLBI = 5'b10010;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_BTR  = 5'b11001;

  localparam logic [REG_W-1:0] LINK_REG = 3'd7;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/id_ex_hazard_reg_usage_decode.sv
// Combinational register-usage decoder: which register fields an instruction
// reads and which one it writes. Shared with the forwarding unit.
module reg_usage_decode
  import id_ex_hazard_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic              src1_v,
  output logic [REG_W-1:0]  src1,
  output logic              src2_v,
  output logic [REG_W-1:0]  src2,
  output logic              dst_v,
  output logic [REG_W-1:0]  dst
);

  logic [4:0] op;
  logic       unused_imm_bits;

  assign op              = inst[15:11];
  assign src1            = inst[10:8];
  assign src2            = inst[7:5];
  assign unused_imm_bits = ^inst[1:0];

  always_comb begin
    src1_v = 1'b0;
    src2_v = 1'b0;
    dst_v  = 1'b0;
    dst    = '0;
    casez (op)
      5'b010??, 5'b101??: begin
        src1_v = 1'b1;
        dst_v  = 1'b1;
        dst    = inst[7:5];
      end
      OP_ST: begin
        src1_v = 1'b1;
        src2_v = 1'b1;
      end
      OP_LD: begin
        src1_v = 1'b1;
        dst_v  = 1'b1;
        dst    = inst[7:5];
      end
      OP_STU: begin
        src1_v = 1'b1;
        src2_v = 1'b1;
        dst_v  = 1'b1;
        dst    = inst[10:8];
      end
      OP_SLBI: begin
        src1_v = 1'b1;
        dst_v  = 1'b1;
        dst    = inst[10:8];
      end
      OP_LBI: begin
        dst_v = 1'b1;
        dst   = inst[10:8];
      end
      OP_BTR: begin
        src1_v = 1'b1;
        dst_v  = 1'b1;
        dst    = inst[4:2];
      end
      5'b1101?, 5'b111??: begin
        src1_v = 1'b1;
        src2_v = 1'b1;
        dst_v  = 1'b1;
        dst    = inst[4:2];
      end
      5'b011??, OP_JR: begin
        src1_v = 1'b1;
      end
      OP_JAL: begin
        dst_v = 1'b1;
        dst   = LINK_REG;
      end
      OP_JALR: begin
        src1_v = 1'b1;
        dst_v  = 1'b1;
        dst    = LINK_REG;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/id_ex_hazard.sv
// ID/EX issue stage: scoreboard-based RAW stall (no forwarding), NOP bubbles on
// stall/flush/fetch bubble, and a saturating stall counter.
module id_ex_hazard
  import id_ex_hazard_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst_dec,
  input  logic              inst_dec_valid,
  input  logic              flush,
  output logic              stall,
  output logic [INST_W-1:0] inst_ex,
  output logic [15:0]       stall_count
);

  logic             src1_v, src2_v, dst_v;
  logic [REG_W-1:0] src1, src2, dst;
  logic             hazard;
  logic             issue;
  sb_entry_t        sb [DEPTH];

  reg_usage_decode u_decode (
    .inst   (inst_dec),
    .src1_v (src1_v),
    .src1   (src1),
    .src2_v (src2_v),
    .src2   (src2),
    .dst_v  (dst_v),
    .dst    (dst)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb[i].valid &&
          ((src1_v && (src1 == sb[i].dst)) || (src2_v && (src2 == sb[i].dst))))
        hazard = 1'b1;
    end
  end

  // Flush outranks everything, so a wrong-path hazard never costs a stall cycle.
  assign stall = !flush && inst_dec_valid && hazard;
  assign issue = !flush && inst_dec_valid && !hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_ex     <= NOP_INST;
      stall_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        sb[i] <= '0;
    end else begin
      inst_ex <= issue ? inst_dec : NOP_INST;
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      // Shift every cycle so bubbles age producers out while decode is frozen.
      sb[0] <= '{valid: issue && dst_v, dst: dst};
      for (int i = 1; i < DEPTH; i++)
        sb[i] <= sb[i-1];
    end
  end

endmodule
